// File: rtl/l1_ahb_mtx_pkg.sv
// Shared definitions for the AHB-Lite bus matrix.
// Holds the HTRANS encodings, HRESP values and the default address and
// address-user widths used by the matrix input and output stages.
package l1_ahb_mtx_pkg;

    localparam int unsigned ADDR_W_DFLT  = 32;
    localparam int unsigned AUSER_W_DFLT = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // NONSEQ and SEQ carry a transfer; IDLE and BUSY never request one.
    function automatic logic is_active_trans(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/l1_ahb_mtx_in_stg_if.sv
// Bus bundle for one matrix input stage.
// Carries the master-side address phase (HSELS..HREADYS), the response
// towards the master (HREADYOUTS, HRESPS), the address phase presented to
// the output stages (*_op outputs, sel_op, held_tran_op) and the grant and
// data-phase response coming back (active_op, hreadymux_op, readyout_op,
// resp_op).
//   slave  : view of the input stage itself
//   master : view of whatever drives the input stage (master + output stage)
interface l1_ahb_mtx_in_stg_if
    import l1_ahb_mtx_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DFLT,
    parameter int unsigned AUSER_W = AUSER_W_DFLT
);

    logic                HSELS;
    logic [ADDR_W-1:0]   HADDRS;
    logic [AUSER_W-1:0]  HAUSERS;
    logic [1:0]          HTRANSS;
    logic                HWRITES;
    logic [2:0]          HSIZES;
    logic [2:0]          HBURSTS;
    logic [3:0]          HPROTS;
    logic [3:0]          HMASTERS;
    logic                HMASTLOCKS;
    logic                HREADYS;
    logic                HREADYOUTS;
    logic                HRESPS;

    logic                active_op;
    logic                hreadymux_op;
    logic                readyout_op;
    logic                resp_op;

    logic                sel_op;
    logic [ADDR_W-1:0]   addr_op;
    logic [AUSER_W-1:0]  auser_op;
    logic [1:0]          trans_op;
    logic                write_op;
    logic [2:0]          size_op;
    logic [2:0]          burst_op;
    logic [3:0]          prot_op;
    logic [3:0]          master_op;
    logic                mastlock_op;
    logic                held_tran_op;

    modport slave (
        input  HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS,
               HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
               active_op, hreadymux_op, readyout_op, resp_op,
        output HREADYOUTS, HRESPS,
               sel_op, addr_op, auser_op, trans_op, write_op, size_op,
               burst_op, prot_op, master_op, mastlock_op, held_tran_op
    );

    modport master (
        output HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS,
               HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
               active_op, hreadymux_op, readyout_op, resp_op,
        input  HREADYOUTS, HRESPS,
               sel_op, addr_op, auser_op, trans_op, write_op, size_op,
               burst_op, prot_op, master_op, mastlock_op, held_tran_op
    );

endinterface

// File: rtl/l1_ahb_mtx_in_stg.sv
// AHB-Lite bus-matrix input stage (one per master port).
// Passes the master's address phase straight through to the output stages
// when granted in the same cycle; otherwise holds it in a register and
// stalls the master until the output stage takes it. Routes the selected
// slave's data-phase HREADYOUT/HRESP back to the master.
// Ports:
//   HCLK     : AHB clock
//   HRESETn  : asynchronous active-low reset
//   bus      : l1_ahb_mtx_in_stg_if.slave (master side, output-stage side)
module l1_ahb_mtx_in_stg
    import l1_ahb_mtx_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DFLT,
    parameter int unsigned AUSER_W = AUSER_W_DFLT
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    l1_ahb_mtx_in_stg_if.slave bus
);

    logic                r_pend;
    logic                r_dphase;
    logic [ADDR_W-1:0]   r_addr;
    logic [AUSER_W-1:0]  r_auser;
    logic [1:0]          r_trans;
    logic                r_write;
    logic [2:0]          r_size;
    logic [2:0]          r_burst;
    logic [3:0]          r_prot;
    logic [3:0]          r_master;
    logic                r_lock;

    logic                w_new_tran;
    logic                w_held;
    logic                w_accept;

    always_comb begin
        w_new_tran = bus.HSELS & is_active_trans(bus.HTRANSS) & bus.HREADYS;
        w_held     = r_pend | w_new_tran;
        w_accept   = bus.active_op & bus.hreadymux_op & w_held;
    end

    // Capture only a live transfer that the output stage did not take this
    // cycle; a same-cycle grant bypasses the register entirely.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend   <= 1'b0;
            r_addr   <= '0;
            r_auser  <= '0;
            r_trans  <= '0;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_burst  <= '0;
            r_prot   <= '0;
            r_master <= '0;
            r_lock   <= 1'b0;
        end else if (w_new_tran && !w_accept) begin
            r_pend   <= 1'b1;
            r_addr   <= bus.HADDRS;
            r_auser  <= bus.HAUSERS;
            r_trans  <= bus.HTRANSS;
            r_write  <= bus.HWRITES;
            r_size   <= bus.HSIZES;
            r_burst  <= bus.HBURSTS;
            r_prot   <= bus.HPROTS;
            r_master <= bus.HMASTERS;
            r_lock   <= bus.HMASTLOCKS;
        end else if (w_accept) begin
            r_pend   <= 1'b0;
        end
    end

    // Accept wins over completion so back-to-back transfers keep the flag set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dphase <= 1'b0;
        end else if (w_accept) begin
            r_dphase <= 1'b1;
        end else if (bus.readyout_op) begin
            r_dphase <= 1'b0;
        end
    end

    always_comb begin
        bus.sel_op       = bus.HSELS & bus.HREADYS;
        bus.addr_op      = bus.HADDRS;
        bus.auser_op     = bus.HAUSERS;
        bus.trans_op     = bus.HTRANSS;
        bus.write_op     = bus.HWRITES;
        bus.size_op      = bus.HSIZES;
        bus.burst_op     = bus.HBURSTS;
        bus.prot_op      = bus.HPROTS;
        bus.master_op    = bus.HMASTERS;
        bus.mastlock_op  = bus.HMASTLOCKS;
        bus.held_tran_op = w_held;
        bus.HREADYOUTS   = ~r_pend;
        bus.HRESPS       = HRESP_OKAY;
        if (r_pend) begin
            // Held entries were captured only with HSELS set.
            bus.sel_op      = 1'b1;
            bus.addr_op     = r_addr;
            bus.auser_op    = r_auser;
            bus.trans_op    = r_trans;
            bus.write_op    = r_write;
            bus.size_op     = r_size;
            bus.burst_op    = r_burst;
            bus.prot_op     = r_prot;
            bus.master_op   = r_master;
            bus.mastlock_op = r_lock;
        end
        if (r_dphase) begin
            bus.HREADYOUTS = bus.readyout_op;
            bus.HRESPS     = bus.resp_op;
        end
    end

endmodule

// File: tb/tb_l1_ahb_mtx_in_stg.sv
module tb_l1_ahb_mtx_in_stg;
    import l1_ahb_mtx_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        r_hrdy_ovr;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [127:0] sb_q[$];

    l1_ahb_mtx_in_stg_if #(.ADDR_W(32), .AUSER_W(32)) bus ();

    l1_ahb_mtx_in_stg #(.ADDR_W(32), .AUSER_W(32)) u_dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    // Single master on the port: its bus HREADY is the stage's own HREADYOUTS.
    // The override forces a capture while a data phase is still stalled.
    assign bus.HREADYS = bus.HREADYOUTS | r_hrdy_ovr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] pack(input logic sel, input logic [31:0] auser,
                                          input logic [31:0] addr, input logic [1:0] trans,
                                          input logic write, input logic [2:0] size,
                                          input logic [2:0] burst, input logic [3:0] prot,
                                          input logic [3:0] master, input logic lock);
        return 128'({sel, auser, addr, trans, write, size, burst, prot, master, lock});
    endfunction

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic drive(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [2:0] burst, input logic lock,
                         input logic push);
        bus.HSELS      = sel;
        bus.HTRANSS    = tr;
        bus.HADDRS     = a;
        bus.HWRITES    = w;
        bus.HBURSTS    = burst;
        bus.HMASTLOCKS = lock;
        bus.HSIZES     = 3'b010;
        bus.HAUSERS    = $urandom;
        bus.HPROTS     = 4'($urandom);
        bus.HMASTERS   = 4'($urandom);
        if (push)
            sb_q.push_back(pack(1'b1, bus.HAUSERS, a, tr, w, 3'b010, burst,
                                bus.HPROTS, bus.HMASTERS, lock));
    endtask

    task automatic slv(input logic act, input logic hmux, input logic rdy, input logic resp);
        bus.active_op    = act;
        bus.hreadymux_op = hmux;
        bus.readyout_op  = rdy;
        bus.resp_op      = resp;
    endtask

    task automatic idle();
        drive(1'b0, HTRANS_IDLE, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    // Every address phase the output stage takes must match the oldest issued one.
    always @(negedge HCLK) begin
        logic [127:0] e;
        if (HRESETn === 1'b1 && bus.active_op && bus.hreadymux_op && bus.held_tran_op) begin
            chk("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("addr_phase", pack(bus.sel_op, bus.auser_op, bus.addr_op, bus.trans_op,
                                       bus.write_op, bus.size_op, bus.burst_op, bus.prot_op,
                                       bus.master_op, bus.mastlock_op), e);
            end
        end
    end

    initial begin
        r_hrdy_ovr = 1'b0;
        HRESETn    = 1'b0;
        slv(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, HTRANS_IDLE, 32'h0000_ABCD, 1'b0, 3'b000, 1'b0, 1'b0);
        mid();
        chk("rst_hready", 128'(bus.HREADYOUTS), 128'd1);
        chk("rst_hresp",  128'(bus.HRESPS), 128'(HRESP_OKAY));
        chk("rst_held",   128'(bus.held_tran_op), 128'd0);
        chk("rst_addr",   128'(bus.addr_op), 128'h0000_ABCD);
        chk("rst_sel",    128'(bus.sel_op), 128'd0);
        cyc(); cyc();
        HRESETn = 1'b1;

        // Zero-wait single transfer
        drive(1'b1, HTRANS_NONSEQ, 32'h0000_1000, 1'b1, 3'b000, 1'b0, 1'b1);
        slv(1'b1, 1'b1, 1'b1, 1'b0);
        mid();
        chk("t1_held",   128'(bus.held_tran_op), 128'd1);
        chk("t1_hready", 128'(bus.HREADYOUTS), 128'd1);
        cyc();
        idle();
        mid();
        chk("t1_dp_hready", 128'(bus.HREADYOUTS), 128'd1);
        chk("t1_dp_hresp",  128'(bus.HRESPS), 128'(HRESP_OKAY));
        chk("t1_dp_held",   128'(bus.held_tran_op), 128'd0);
        cyc();

        // Arbitration loss for three cycles
        drive(1'b1, HTRANS_NONSEQ, 32'h2000_0040, 1'b0, 3'b000, 1'b0, 1'b1);
        slv(1'b0, 1'b1, 1'b1, 1'b0);
        mid();
        chk("t2_cap_held",   128'(bus.held_tran_op), 128'd1);
        chk("t2_cap_hready", 128'(bus.HREADYOUTS), 128'd1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, HTRANS_IDLE, 32'hDEAD_0000 + 32'(i * 4), 1'b1, 3'b001, 1'b1, 1'b0);
            mid();
            chk("t2_wait_hready", 128'(bus.HREADYOUTS), 128'd0);
            chk("t2_wait_addr",   128'(bus.addr_op), 128'h2000_0040);
            chk("t2_wait_held",   128'(bus.held_tran_op), 128'd1);
            cyc();
        end
        slv(1'b1, 1'b1, 1'b0, 1'b0);
        mid();
        chk("t2_acc_hready", 128'(bus.HREADYOUTS), 128'd0);
        cyc();
        mid();
        chk("t2_dp_wait", 128'(bus.HREADYOUTS), 128'd0);
        chk("t2_dp_held", 128'(bus.held_tran_op), 128'd0);
        cyc();
        slv(1'b1, 1'b1, 1'b1, 1'b0);
        mid();
        chk("t2_dp_done", 128'(bus.HREADYOUTS), 128'd1);
        cyc();

        // INCR4 back-to-back
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h100 + 32'(4 * k),
                  1'b0, 3'b011, 1'b0, 1'b1);
            slv(1'b1, 1'b1, 1'b1, 1'b0);
            mid();
            chk("t3_hready", 128'(bus.HREADYOUTS), 128'd1);
            chk("t3_addr",   128'(bus.addr_op), 128'(32'h100 + 32'(4 * k)));
            cyc();
        end
        idle();
        slv(1'b1, 1'b1, 0, 1'b1);
        mid();
        // The last beat's data phase must still be live: response is routed.
        chk("t3_last_dp_hready", 128'(bus.HREADYOUTS), 128'd0);
        chk("t3_last_dp_hresp",  128'(bus.HRESPS), 128'd1);
        cyc();
        slv(1'b1, 1'b1, 1'b1, 1'b0);
        mid();
        chk("t3_last_done", 128'(bus.HREADYOUTS), 128'd1);
        cyc();

        // Slave wait states with a pipelined next address
        drive(1'b1, HTRANS_NONSEQ, 32'h300, 1'b1, 3'b000, 1'b0, 1'b1);
        slv(1'b1, 1'b1, 1'b1, 1'b0);
        mid();
        cyc();
        drive(1'b1, HTRANS_NONSEQ, 32'h304, 1'b0, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            slv(1'b1, 1'b1, 1'b0, 1'b0);
            mid();
            chk("t4_ws_hready", 128'(bus.HREADYOUTS), 128'd0);
            chk("t4_ws_held",   128'(bus.held_tran_op), 128'd0);
            cyc();
        end
        slv(1'b1, 1'b1, 1'b1, 1'b0);
        mid();
        chk("t4_rel_hready", 128'(bus.HREADYOUTS), 128'd1);
        chk("t4_rel_held",   128'(bus.held_tran_op), 128'd1);
        cyc();
        idle();
        mid();
        chk("t4_dp_hready", 128'(bus.HREADYOUTS), 128'd1);
        cyc();

        // Two-cycle ERROR, master goes IDLE
        drive(1'b1, HTRANS_NONSEQ, 32'h400, 1'b1, 3'b000, 1'b0, 1'b1);
        slv(1'b1, 1'b1, 1'b1, 1'b0);
        mid();
        cyc();
        idle();
        slv(1'b1, 1'b1, 1'b0, HRESP_ERROR);
        mid();
        chk("t5_err1_hresp",  128'(bus.HRESPS), 128'(HRESP_ERROR));
        chk("t5_err1_hready", 128'(bus.HREADYOUTS), 128'd0);
        chk("t5_err1_held",   128'(bus.held_tran_op), 128'd0);
        cyc();
        slv(1'b1, 1'b1, 1'b1, HRESP_ERROR);
        mid();
        chk("t5_err2_hresp",  128'(bus.HRESPS), 128'(HRESP_ERROR));
        chk("t5_err2_hready", 128'(bus.HREADYOUTS), 128'd1);
        chk("t5_err2_held",   128'(bus.held_tran_op), 128'd0);
        cyc();
        slv(1'b1, 1'b1, 1'b1, HRESP_ERROR);
        mid();
        chk("t5_after_hresp", 128'(bus.HRESPS), 128'(HRESP_OKAY));
        chk("t5_after_held",  128'(bus.held_tran_op), 128'd0);
        cyc();

        // Async reset with both a held transfer and a live data phase
        drive(1'b1, HTRANS_NONSEQ, 32'h500, 1'b0, 3'b000, 1'b1, 1'b1);
        slv(1'b1, 1'b1, 1'b1, 1'b0);
        mid();
        cyc();
        drive(1'b1, HTRANS_NONSEQ, 32'h504, 1'b0, 3'b000, 1'b1, 1'b0);
        slv(1'b0, 1'b1, 1'b0, 1'b1);
        r_hrdy_ovr = 1'b1;
        mid();
        chk("t6_cap_held", 128'(bus.held_tran_op), 128'd1);
        cyc();
        r_hrdy_ovr = 1'b0;
        idle();
        mid();
        chk("t6_pre_hready", 128'(bus.HREADYOUTS), 128'd0);
        chk("t6_pre_hresp",  128'(bus.HRESPS), 128'd1);
        chk("t6_pre_held",   128'(bus.held_tran_op), 128'd1);
        chk("t6_pre_addr",   128'(bus.addr_op), 128'h504);
        #1;
        HRESETn = 1'b0;
        #1;
        chk("t6_rst_hready", 128'(bus.HREADYOUTS), 128'd1);
        chk("t6_rst_hresp",  128'(bus.HRESPS), 128'(HRESP_OKAY));
        chk("t6_rst_held",   128'(bus.held_tran_op), 128'd0);
        cyc(); cyc();
        HRESETn = 1'b1;
        drive(1'b1, HTRANS_NONSEQ, 32'h600, 1'b1, 3'b000, 1'b0, 1'b1);
        slv(1'b1, 1'b1, 1'b1, 1'b0);
        mid();
        chk("t6_post_held",   128'(bus.held_tran_op), 128'd1);
        chk("t6_post_hready", 128'(bus.HREADYOUTS), 128'd1);
        cyc();
        idle();
        mid();
        chk("t6_post_dp", 128'(bus.HREADYOUTS), 128'd1);
        cyc();

        chk("sb_drain", 128'(sb_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
